// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one single-port memory bus between the instruction-fetch
// and data-stage requesters. The data requester wins ties. Each granted access
// is held on the bus until acked, then gets a one-cycle DONE state in which the
// requester's stall drops. An exception flush lets the bus access finish and
// then throws the result away.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   if_ce_i, if_addr_i        fetch request (read, all byte lanes)
//   if_data_o, if_stall_o     fetched word; fetch not yet complete
//   mem_ce_i .. mem_data_i    data-stage request (we already exception-masked)
//   mem_data_o, mem_stall_o   load result; data access not yet complete
//   flush_i                   exception flush
//   bus_req_o .. bus_wdata_o  registered bus request fields
//   bus_rdata_i, bus_ack_i    bus completion; rdata valid with ack
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stall_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stall_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [2:0] {StIdle, StBusyD, StBusyI, StDoneD, StDoneI} state_e;

    state_e      r_state, w_state_d;
    logic        r_flush_pending, w_flush_pending_d;
    logic        r_req, w_req_d;
    logic        r_we, w_we_d;
    logic [31:0] r_addr, w_addr_d;
    logic [3:0]  r_sel, w_sel_d;
    logic [31:0] r_wdata, w_wdata_d;
    logic [31:0] r_if_data, w_if_data_d;
    logic [31:0] r_mem_data, w_mem_data_d;
    logic        w_flush;

    // A flush arriving in the ack cycle itself also discards the result.
    assign w_flush = r_flush_pending | flush_i;

    always_comb begin
        w_state_d         = r_state;
        w_flush_pending_d = r_flush_pending;
        w_req_d           = r_req;
        w_we_d            = r_we;
        w_addr_d          = r_addr;
        w_sel_d           = r_sel;
        w_wdata_d         = r_wdata;
        w_if_data_d       = r_if_data;
        w_mem_data_d      = r_mem_data;
        case (r_state)
            StIdle: begin
                w_flush_pending_d = 1'b0;
                if (!flush_i) begin
                    if (mem_ce_i) begin
                        w_state_d = StBusyD;
                        w_req_d   = 1'b1;
                        w_we_d    = mem_we_i;
                        w_addr_d  = mem_addr_i;
                        w_sel_d   = mem_sel_i;
                        w_wdata_d = mem_data_i;
                    end else if (if_ce_i) begin
                        w_state_d = StBusyI;
                        w_req_d   = 1'b1;
                        w_we_d    = 1'b0;
                        w_addr_d  = if_addr_i;
                        w_sel_d   = 4'b1111;
                        w_wdata_d = 32'h0;
                    end
                end
            end
            StBusyD: begin
                if (flush_i) begin
                    w_flush_pending_d = 1'b1;
                end
                if (bus_ack_i) begin
                    w_req_d = 1'b0;
                    if (w_flush) begin
                        w_state_d         = StIdle;
                        w_flush_pending_d = 1'b0;
                    end else begin
                        w_state_d = StDoneD;
                        if (!r_we) begin
                            w_mem_data_d = bus_rdata_i;
                        end
                    end
                end
            end
            StBusyI: begin
                if (flush_i) begin
                    w_flush_pending_d = 1'b1;
                end
                if (bus_ack_i) begin
                    w_req_d = 1'b0;
                    if (w_flush) begin
                        w_state_d         = StIdle;
                        w_flush_pending_d = 1'b0;
                    end else begin
                        w_state_d   = StDoneI;
                        w_if_data_d = bus_rdata_i;
                    end
                end
            end
            StDoneD, StDoneI: begin
                w_state_d         = StIdle;
                w_flush_pending_d = 1'b0;
            end
            default: begin
                w_state_d         = StIdle;
                w_flush_pending_d = 1'b0;
                w_req_d           = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= StIdle;
            r_flush_pending <= 1'b0;
            r_req           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= 32'h0;
            r_sel           <= 4'h0;
            r_wdata         <= 32'h0;
            r_if_data       <= 32'h0;
            r_mem_data      <= 32'h0;
        end else begin
            r_state         <= w_state_d;
            r_flush_pending <= w_flush_pending_d;
            r_req           <= w_req_d;
            r_we            <= w_we_d;
            r_addr          <= w_addr_d;
            r_sel           <= w_sel_d;
            r_wdata         <= w_wdata_d;
            r_if_data       <= w_if_data_d;
            r_mem_data      <= w_mem_data_d;
        end
    end

    assign bus_req_o   = r_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;
    assign if_data_o   = r_if_data;
    assign mem_data_o  = r_mem_data;
    assign mem_stall_o = mem_ce_i & (r_state != StDoneD);
    assign if_stall_o  = if_ce_i & (r_state != StDoneI);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: table of single accesses plus hand-written sequences
// for contention, flush and mid-transaction reset. Expected bus requests are
// queued when stimulus is driven and checked when bus_req_o rises.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i, mem_ce_i, mem_we_i, flush_i, bus_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_data_i, bus_rdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] if_data_o, mem_data_o, bus_addr_o, bus_wdata_o;
    logic        if_stall_o, mem_stall_o, bus_req_o, bus_we_o;
    logic [3:0]  bus_sel_o;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_ce_i    (if_ce_i),
        .if_addr_i  (if_addr_i),
        .if_data_o  (if_data_o),
        .if_stall_o (if_stall_o),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_stall_o(mem_stall_o),
        .flush_i    (flush_i),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_sel_o  (bus_sel_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i  (bus_ack_i)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    sb[$];
    bus_exp_t    cur;
    vec_t        vecs[5];
    int          n_vec = 0;
    int          n_miss = 0;
    int          rsp_cnt = 0;
    int          rsp_lat = 0;
    logic [31:0] rsp_data = 32'h0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_if = 32'h0;
    logic [31:0] exp_mem = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                            input logic [31:0] wdata);
        bus_exp_t e;
        e.addr  = addr;
        e.we    = we;
        e.sel   = sel;
        e.wdata = wdata;
        sb.push_back(e);
    endtask

    // Advance one cycle: bus responder acks after rsp_lat request cycles
    // (0 = never), then the monitor checks the bus against the scoreboard.
    task automatic step();
        @(negedge clk);
        if (bus_req_o) begin
            rsp_cnt++;
            bus_ack_i   = (rsp_cnt == rsp_lat);
            bus_rdata_i = bus_ack_i ? rsp_data : 32'h5A5A_5A5A;
        end else begin
            rsp_cnt     = 0;
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'h5A5A_5A5A;
        end
        #1;
        if (bus_req_o) begin
            if (!prev_req) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb_unexpected_req: got addr %h, want no request", bus_addr_o);
                end else begin
                    cur = sb.pop_front();
                end
            end
            chk("bus_addr", bus_addr_o, cur.addr);
            chk("bus_we", 32'(bus_we_o), 32'(cur.we));
            chk("bus_sel", 32'(bus_sel_o), 32'(cur.sel));
            chk("bus_wdata", bus_wdata_o, cur.wdata);
        end
        prev_req = bus_req_o;
    endtask

    task automatic run_vec(input vec_t v);
        int  stalls;
        logic done;
        mem_ce_i   = v.is_data;
        mem_we_i   = v.we;
        mem_addr_i = v.is_data ? v.addr : 32'hFFFF_0000;
        mem_sel_i  = v.sel;
        mem_data_i = v.wdata;
        if_ce_i    = !v.is_data;
        if_addr_i  = v.is_data ? 32'hEEEE_0000 : v.addr;
        rsp_lat    = v.lat;
        rsp_data   = v.rdata;
        if (v.is_data) push_exp(v.addr, v.we, v.sel, v.wdata);
        else           push_exp(v.addr, 1'b0, 4'hF, 32'h0);
        #1;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (v.is_data ? mem_stall_o : if_stall_o) begin
                stalls++;
                step();
            end else begin
                done = 1'b1;
                break;
            end
        end
        chk("vec_done", 32'(done), 32'd1);
        chk("vec_stall_cycles", 32'(stalls), 32'(v.lat + 1));
        if (v.is_data && !v.we) exp_mem = v.rdata;
        if (!v.is_data)         exp_if  = v.rdata;
        chk("vec_mem_data", mem_data_o, exp_mem);
        chk("vec_if_data", if_data_o, exp_if);
        chk("vec_done_req_low", 32'(bus_req_o), 32'd0);
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
        if_ce_i  = 1'b0;
        step();
    endtask

    initial begin
        int mcnt;
        int icnt;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 2, 32'h3C01_0001};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0, 1, 32'h8C22_0004};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2004, 4'h3, 32'hDEAD_BEEF, 3, 32'h1111_1111};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 1, 32'h2442_0001};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_2008, 4'h1, 32'h0, 4, 32'h0000_00A5};

        rst = 1'b0;
        if_ce_i = 1'b1; mem_ce_i = 1'b1; mem_we_i = 1'b0; flush_i = 1'b0;
        if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_sel_i = 4'h0; mem_data_i = 32'h0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        step();
        step();
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_bus_sel", 32'(bus_sel_o), 32'h0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_if_stall_ce", 32'(if_stall_o), 32'd1);
        chk("rst_mem_stall_ce", 32'(mem_stall_o), 32'd1);
        if_ce_i = 1'b0; mem_ce_i = 1'b0;
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Simultaneous load and fetch: load first, fetch granted after DONE_D.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_2000; mem_sel_i = 4'hF;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_3000;
        rsp_lat = 2; rsp_data = 32'h8C01_0010;
        push_exp(32'h0000_2000, 1'b0, 4'hF, 32'h0);
        push_exp(32'h0000_3000, 1'b0, 4'hF, 32'h0);
        #1;
        mcnt = 0;
        icnt = 0;
        for (int i = 0; i < 40 && mem_stall_o; i++) begin
            mcnt++;
            if (if_stall_o) icnt++;
            step();
        end
        chk("sim_mem_stall_cycles", 32'(mcnt), 32'd3);
        chk("sim_mem_data", mem_data_o, 32'h8C01_0010);
        exp_mem = 32'h8C01_0010;
        chk("sim_if_stall_in_done_d", 32'(if_stall_o), 32'd1);
        mem_ce_i = 1'b0;
        rsp_data = 32'h3C1F_0000;
        for (int i = 0; i < 40 && if_stall_o; i++) begin
            icnt++;
            step();
        end
        chk("sim_if_stall_cycles", 32'(icnt), 32'd7);
        chk("sim_if_data", if_data_o, 32'h3C1F_0000);
        exp_if = 32'h3C1F_0000;
        if_ce_i = 1'b0;
        step();

        // Flush while fetch is on the bus: access runs to ack, result dropped.
        if_ce_i = 1'b1; if_addr_i = 32'h0000_4000;
        rsp_lat = 3; rsp_data = 32'h0BAD_0BAD;
        push_exp(32'h0000_4000, 1'b0, 4'hF, 32'h0);
        #1;
        step();
        chk("fl_req_granted", 32'(bus_req_o), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fl_req_held", 32'(bus_req_o), 32'd1);
        step();
        chk("fl_req_held_ack", 32'(bus_req_o), 32'd1);
        chk("fl_ack_cycle", 32'(bus_ack_i), 32'd1);
        step();
        chk("fl_req_dropped", 32'(bus_req_o), 32'd0);
        chk("fl_no_done_i", 32'(if_stall_o), 32'd1);
        chk("fl_if_data_kept", if_data_o, exp_if);
        if_ce_i = 1'b0;
        step();
        chk("fl_idle_no_regrant", 32'(bus_req_o), 32'd0);

        // Reset during an unacked load.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_5000; mem_sel_i = 4'hF;
        rsp_lat = 0;
        push_exp(32'h0000_5000, 1'b0, 4'hF, 32'h0);
        #1;
        step();
        chk("rd_req_before", 32'(bus_req_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("rd_req_async", 32'(bus_req_o), 32'd0);
        chk("rd_addr", bus_addr_o, 32'h0);
        chk("rd_sel", 32'(bus_sel_o), 32'h0);
        chk("rd_mem_data", mem_data_o, 32'h0);
        chk("rd_if_data", if_data_o, 32'h0);
        chk("rd_mem_stall_ce", 32'(mem_stall_o), 32'd1);
        exp_mem = 32'h0;
        exp_if  = 32'h0;
        mem_ce_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rd_idle_after", 32'(bus_req_o), 32'd0);
        run_vec('{1'b0, 1'b0, 32'h0000_1008, 4'hF, 32'h0, 2, 32'h0000_0021});

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have ports: if_ce_i in 1, if_addr_i in 32: instruction fetch request (read-only, sel 4'b1111).
REQ-004 SHALL have ports: if_data_o out 32 fetched word; if_stall_o out 1 fetch not complete.
REQ-005 SHALL have ports: mem_ce_i in 1, mem_we_i in 1, mem_addr_i in 32, mem_sel_i in 4, mem_data_i in 32: data-stage request; mem_we_i is already exception-masked upstream.
REQ-006 SHALL have ports: mem_data_o out 32 load result; mem_stall_o out 1 data access not complete.
REQ-007 SHALL have port: flush_i  in  1  exception flush from CP0 control.
REQ-008 SHALL have ports: bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_sel_o out 4, bus_wdata_o out 32: shared single-port memory bus.
REQ-009 SHALL have ports: bus_rdata_i in 32, bus_ack_i in 1: bus completion; rdata valid when ack high.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I.
REQ-011 IDLE: if flush_i=1 -> stay IDLE, no grant; else mem_ce_i=1 -> BUSY_D; else if_ce_i=1 -> BUSY_I; else stay IDLE.
REQ-012 Data requester SHALL have fixed priority over fetch on simultaneous requests in IDLE.
REQ-013 On grant, bus_addr/we/sel/wdata SHALL be registered from the granted requester (fetch: we=0, sel=4'b1111, wdata=0) and bus_req_o=1 from the next cycle.
REQ-014 In BUSY_*: bus_req_o and all bus_* fields SHALL stay stable until the cycle bus_ack_i=1; bus_ack_i is ignored in IDLE/DONE_*.
REQ-015 ack in the first cycle of bus_req_o SHALL be accepted (minimum bus latency 1 cycle).
REQ-016 On ack in BUSY_D: bus_req_o->0, bus_rdata_i registered into mem_data_o, next state DONE_D (or IDLE if flush pending).
REQ-017 On ack in BUSY_I: bus_req_o->0, bus_rdata_i registered into if_data_o, next state DONE_I (or IDLE if flush pending).
REQ-018 DONE_D/DONE_I SHALL last exactly one cycle, then IDLE; new requests are not sampled in DONE_*.
REQ-019 mem_stall_o SHALL be combinational: mem_ce_i & (state != DONE_D).
REQ-020 if_stall_o SHALL be combinational: if_ce_i & (state != DONE_I).
REQ-021 if_data_o / mem_data_o SHALL hold their last value outside the capture cycle; stores do not update mem_data_o.
REQ-022 flush_i=1 in BUSY_*: bus transaction SHALL run to ack (no abort); internal flush_pending set; result discarded, return to IDLE, no DONE_* cycle.
REQ-023 flush_pending SHALL clear on entry to IDLE; flush_i in DONE_* has no effect on the DONE cycle.
REQ-024 Latency per access without flush: grant edge + N bus cycles + 1 DONE cycle; stall low only in DONE.
REQ-025 No wait timeout; a bus that never acks holds BUSY_* indefinitely.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, flush_pending=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0, if_data_o=0, mem_data_o=0.
REQ-027 Reset asserted mid-transaction SHALL drop bus_req_o asynchronously; the pending access is lost and not retried.
REQ-028 Stall outputs remain ce-driven during reset (state IDLE => stall = ce).

Verification
REQ-029 Fetch only: if_ce_i=1, addr 0x1000, ack after 2 cycles with rdata 0x3C010001 -> if_stall_o high 3 cycles, low 1 cycle, if_data_o=0x3C010001.
REQ-030 Simultaneous: mem_ce_i=1 (lw 0x2000), if_ce_i=1 -> data served first, bus_addr_o=0x2000; fetch granted only after DONE_D->IDLE.
REQ-031 Store: mem_we_i=1, sel 4'b0011, data 0xDEADBEEF -> bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=0xDEADBEEF stable until ack; mem_data_o unchanged.
REQ-032 Flush during BUSY_I: flush_i pulse before ack -> bus_req_o held to ack, if_data_o unchanged, FSM to IDLE with no DONE_I.
REQ-033 Reset (rst=0) during BUSY_D with bus_req_o=1 -> bus_req_o=0 same cycle, all outputs per REQ-026, IDLE after release.
REQ-034 Ack in first req cycle: bus_ack_i=1 with bus_req_o rise -> DONE next cycle, total stall 2 cycles.
